// File: rtl/cellrv32_busswitch_pkg.sv
// Shared types for the two-port-to-one bus switch: arbiter state and
// per-port pending-request buffer.
package cellrv32_busswitch_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_A = 2'd1,
        S_BUSY_B = 2'd2
    } bus_state_t;

    typedef struct packed {
        logic rd;
        logic wr;
    } pend_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    function automatic logic pend_any(input pend_t p);
        return p.rd | p.wr;
    endfunction

endpackage

// File: rtl/cellrv32_busswitch_reqbuf.sv
// Per-port request capture: latches one read/write pulse until issued and
// answers writes on a read-only port with a one-cycle error.
module cellrv32_busswitch_reqbuf
    import cellrv32_busswitch_pkg::*;
#(
    parameter logic READ_ONLY = 1'b0
) (
    input  logic  i_clk,
    input  logic  i_rstn,
    input  logic  i_re,
    input  logic  i_we,
    input  logic  i_granted,
    input  logic  i_issue,
    output pend_t o_pend,
    output logic  o_ro_err
);

    pend_t r_pend;
    logic  r_ro_err;
    logic  w_accept;

    // A port already waiting or being served drops further pulses.
    assign w_accept = !pend_any(r_pend) && !i_granted;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pend   <= '0;
            r_ro_err <= 1'b0;
        end else begin
            r_ro_err <= READ_ONLY & i_we;
            if (i_issue) begin
                r_pend <= '0;
            end else if (w_accept) begin
                r_pend.rd <= i_re;
                r_pend.wr <= i_we & ~READ_ONLY;
            end
        end
    end

    assign o_pend   = r_pend;
    assign o_ro_err = r_ro_err;

endmodule

// File: rtl/cellrv32_busswitch.sv
// Arbitrates the CPU data port (A) and instruction fetch port (B) onto one
// host bus; one transfer in flight, responses routed back to the granted port.
module cellrv32_busswitch
    import cellrv32_busswitch_pkg::*;
#(
    parameter logic PORT_A_READ_ONLY = 1'b0,
    parameter logic PORT_B_READ_ONLY = 1'b1,
    parameter logic FAIR_ARB         = 1'b0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] ca_addr_i,
    input  logic [31:0] ca_wdata_i,
    input  logic [3:0]  ca_ben_i,
    input  logic        ca_re_i,
    input  logic        ca_we_i,
    output logic [31:0] ca_rdata_o,
    output logic        ca_ack_o,
    output logic        ca_err_o,
    input  logic [31:0] cb_addr_i,
    input  logic [31:0] cb_wdata_i,
    input  logic [3:0]  cb_ben_i,
    input  logic        cb_re_i,
    input  logic        cb_we_i,
    output logic [31:0] cb_rdata_o,
    output logic        cb_ack_o,
    output logic        cb_err_o,
    output logic        p_src_o,
    output logic [31:0] p_addr_o,
    output logic [31:0] p_wdata_o,
    output logic [3:0]  p_ben_o,
    output logic        p_re_o,
    output logic        p_we_o,
    input  logic [31:0] p_rdata_i,
    input  logic        p_ack_i,
    input  logic        p_err_i
);

    bus_state_t r_state;
    bus_state_t w_state_nxt;
    logic       r_last_b;
    pend_t      w_pend_a;
    pend_t      w_pend_b;
    logic       w_ro_err_a;
    logic       w_ro_err_b;
    logic       w_req_a;
    logic       w_req_b;
    logic       w_issue_a;
    logic       w_issue_b;
    logic       w_sel_b;
    logic       w_gnt_a;
    logic       w_gnt_b;
    logic       w_re;
    logic       w_we;
    logic       w_done;

    cellrv32_busswitch_reqbuf #(.READ_ONLY(PORT_A_READ_ONLY)) u_reqbuf_a (
        .i_clk     (clk_i),
        .i_rstn    (rstn_i),
        .i_re      (ca_re_i),
        .i_we      (ca_we_i),
        .i_granted (r_state == S_BUSY_A),
        .i_issue   (w_issue_a),
        .o_pend    (w_pend_a),
        .o_ro_err  (w_ro_err_a)
    );

    cellrv32_busswitch_reqbuf #(.READ_ONLY(PORT_B_READ_ONLY)) u_reqbuf_b (
        .i_clk     (clk_i),
        .i_rstn    (rstn_i),
        .i_re      (cb_re_i),
        .i_we      (cb_we_i),
        .i_granted (r_state == S_BUSY_B),
        .i_issue   (w_issue_b),
        .o_pend    (w_pend_b),
        .o_ro_err  (w_ro_err_b)
    );

    assign w_req_a = pend_any(w_pend_a);
    assign w_req_b = pend_any(w_pend_b);
    assign w_done  = p_ack_i | p_err_i;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_b     = SRC_A;
        w_issue_a   = 1'b0;
        w_issue_b   = 1'b0;
        w_re        = 1'b0;
        w_we        = 1'b0;
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On a tie, round-robin hands the bus to A only if B was served last.
                if (w_req_a && (!w_req_b || !FAIR_ARB || r_last_b)) begin
                    w_issue_a   = 1'b1;
                    w_re        = w_pend_a.rd;
                    w_we        = w_pend_a.wr;
                    w_state_nxt = S_BUSY_A;
                end else if (w_req_b) begin
                    w_sel_b     = SRC_B;
                    w_issue_b   = 1'b1;
                    w_re        = w_pend_b.rd;
                    w_we        = w_pend_b.wr;
                    w_state_nxt = S_BUSY_B;
                end
            end
            S_BUSY_A: begin
                w_gnt_a = 1'b1;
                if (w_done) w_state_nxt = S_IDLE;
            end
            S_BUSY_B: begin
                w_sel_b = SRC_B;
                w_gnt_b = 1'b1;
                if (w_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= S_IDLE;
            r_last_b <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_BUSY_A && w_done) r_last_b <= 1'b0;
            if (r_state == S_BUSY_B && w_done) r_last_b <= 1'b1;
        end
    end

    assign p_src_o   = w_sel_b;
    assign p_addr_o  = w_sel_b ? cb_addr_i  : ca_addr_i;
    assign p_wdata_o = w_sel_b ? cb_wdata_i : ca_wdata_i;
    assign p_ben_o   = w_sel_b ? cb_ben_i   : ca_ben_i;
    assign p_re_o    = w_re;
    assign p_we_o    = w_we;

    assign ca_rdata_o = w_gnt_a ? p_rdata_i : '0;
    assign ca_ack_o   = w_gnt_a & p_ack_i;
    assign ca_err_o   = (w_gnt_a & p_err_i) | w_ro_err_a;
    assign cb_rdata_o = w_gnt_b ? p_rdata_i : '0;
    assign cb_ack_o   = w_gnt_b & p_ack_i;
    assign cb_err_o   = (w_gnt_b & p_err_i) | w_ro_err_b;

endmodule

// File: tb/tb_cellrv32_busswitch.sv
// Bench for the bus switch: one fixed-priority and one round-robin instance
// share port stimulus; each has its own host responder and expected grant order.
module tb_cellrv32_busswitch;

    logic        clk, rstn;
    logic [31:0] ca_addr, ca_wdata, cb_addr, cb_wdata;
    logic [3:0]  ca_ben, cb_ben;
    logic        ca_re, ca_we, cb_re, cb_we;

    logic [31:0] ca_rdata [2];
    logic [31:0] cb_rdata [2];
    logic        ca_ack [2], ca_err [2], cb_ack [2], cb_err [2];
    logic        p_src [2], p_re [2], p_we [2];
    logic [31:0] p_addr [2], p_wdata [2];
    logic [3:0]  p_ben [2];
    logic        h_ack [2], h_err [2];
    logic [31:0] h_rdata [2];

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model state
    bit          last_b [2];
    int          exp_ord [2][2];
    int          exp_n [2];
    int          t_a_op, t_b_op;
    logic [31:0] t_a_addr, t_b_addr, t_a_wd, t_b_wd;
    logic [3:0]  t_a_ben, t_b_ben;
    int          t_lat [2];
    int          t_resp [2];
    logic [31:0] t_rd [2];

    cellrv32_busswitch #(.FAIR_ARB(1'b0)) dut0 (
        .clk_i(clk), .rstn_i(rstn),
        .ca_addr_i(ca_addr), .ca_wdata_i(ca_wdata), .ca_ben_i(ca_ben),
        .ca_re_i(ca_re), .ca_we_i(ca_we),
        .ca_rdata_o(ca_rdata[0]), .ca_ack_o(ca_ack[0]), .ca_err_o(ca_err[0]),
        .cb_addr_i(cb_addr), .cb_wdata_i(cb_wdata), .cb_ben_i(cb_ben),
        .cb_re_i(cb_re), .cb_we_i(cb_we),
        .cb_rdata_o(cb_rdata[0]), .cb_ack_o(cb_ack[0]), .cb_err_o(cb_err[0]),
        .p_src_o(p_src[0]), .p_addr_o(p_addr[0]), .p_wdata_o(p_wdata[0]),
        .p_ben_o(p_ben[0]), .p_re_o(p_re[0]), .p_we_o(p_we[0]),
        .p_rdata_i(h_rdata[0]), .p_ack_i(h_ack[0]), .p_err_i(h_err[0])
    );

    cellrv32_busswitch #(.FAIR_ARB(1'b1)) dut1 (
        .clk_i(clk), .rstn_i(rstn),
        .ca_addr_i(ca_addr), .ca_wdata_i(ca_wdata), .ca_ben_i(ca_ben),
        .ca_re_i(ca_re), .ca_we_i(ca_we),
        .ca_rdata_o(ca_rdata[1]), .ca_ack_o(ca_ack[1]), .ca_err_o(ca_err[1]),
        .cb_addr_i(cb_addr), .cb_wdata_i(cb_wdata), .cb_ben_i(cb_ben),
        .cb_re_i(cb_re), .cb_we_i(cb_we),
        .cb_rdata_o(cb_rdata[1]), .cb_ack_o(cb_ack[1]), .cb_err_o(cb_err[1]),
        .p_src_o(p_src[1]), .p_addr_o(p_addr[1]), .p_wdata_o(p_wdata[1]),
        .p_ben_o(p_ben[1]), .p_re_o(p_re[1]), .p_we_o(p_we[1]),
        .p_rdata_i(h_rdata[1]), .p_ack_i(h_ack[1]), .p_err_i(h_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not terminate");
    end

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL d%0d_%s observed=%h expected=%h", d, tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk(d, {tag, "_strobe"}, {30'd0, p_re[d], p_we[d]}, 32'd0);
            chk(d, {tag, "_src"}, 32'(p_src[d]), 32'd0);
            chk(d, {tag, "_addr"}, p_addr[d], 32'd0);
            chk(d, {tag, "_wdata"}, p_wdata[d], 32'd0);
            chk(d, {tag, "_ben"}, 32'(p_ben[d]), 32'd0);
            chk(d, {tag, "_resp"}, {28'd0, ca_ack[d], ca_err[d], cb_ack[d], cb_err[d]}, 32'd0);
            chk(d, {tag, "_rdata_a"}, ca_rdata[d], 32'd0);
            chk(d, {tag, "_rdata_b"}, cb_rdata[d], 32'd0);
        end
    endtask

    function automatic int pick_resp();
        int v = int'($urandom_range(0, 19));
        return (v < 14) ? 0 : ((v < 18) ? 1 : 2);
    endfunction

    // Host responder for instance d; entered in the cycle the first strobe is due.
    task automatic host(input int d);
        int          p;
        logic [31:0] g;
        logic        g_ack, g_err, o_ack, o_err;
        logic [31:0] g_rd, o_rd;
        for (int k = 0; k < exp_n[d]; k++) begin
            p = exp_ord[d][k];
            #1;
            chk(d, "p_re", 32'(p_re[d]), 32'((p == 0) ? (t_a_op == 1) : (t_b_op == 1)));
            chk(d, "p_we", 32'(p_we[d]), 32'(p == 0 && t_a_op == 2));
            chk(d, "p_src", 32'(p_src[d]), 32'(p));
            chk(d, "p_addr", p_addr[d], (p == 0) ? t_a_addr : t_b_addr);
            chk(d, "p_wdata", p_wdata[d], (p == 0) ? t_a_wd : t_b_wd);
            chk(d, "p_ben", 32'(p_ben[d]), 32'((p == 0) ? t_a_ben : t_b_ben));
            chk(d, "idle_ack", {30'd0, ca_ack[d], cb_ack[d]}, 32'd0);
            for (int w = 1; w < t_lat[k]; w++) begin
                @(negedge clk);
                g = $urandom;
                h_rdata[d] = g;
                #1;
                g_rd = (p == 0) ? ca_rdata[d] : cb_rdata[d];
                o_rd = (p == 0) ? cb_rdata[d] : ca_rdata[d];
                chk(d, "wait_strobe", {30'd0, p_re[d], p_we[d]}, 32'd0);
                chk(d, "wait_resp", {28'd0, ca_ack[d], ca_err[d], cb_ack[d], cb_err[d]}, 32'd0);
                chk(d, "wait_rdata_gnt", g_rd, g);
                chk(d, "wait_rdata_other", o_rd, 32'd0);
            end
            @(negedge clk);
            h_ack[d]   = (t_resp[k] != 1);
            h_err[d]   = (t_resp[k] != 0);
            h_rdata[d] = t_rd[k];
            #1;
            g_ack = (p == 0) ? ca_ack[d] : cb_ack[d];
            g_err = (p == 0) ? ca_err[d] : cb_err[d];
            g_rd  = (p == 0) ? ca_rdata[d] : cb_rdata[d];
            o_ack = (p == 0) ? cb_ack[d] : ca_ack[d];
            o_err = (p == 0) ? cb_err[d] : ca_err[d];
            o_rd  = (p == 0) ? cb_rdata[d] : ca_rdata[d];
            chk(d, "ack", 32'(g_ack), 32'(t_resp[k] != 1));
            chk(d, "err", 32'(g_err), 32'(t_resp[k] != 0));
            chk(d, "rdata", g_rd, t_rd[k]);
            chk(d, "other_resp", {30'd0, o_ack, o_err}, 32'd0);
            chk(d, "other_rdata", o_rd, 32'd0);
            chk(d, "ack_strobe", {30'd0, p_re[d], p_we[d]}, 32'd0);
            @(negedge clk);
            h_ack[d]   = 1'b0;
            h_err[d]   = 1'b0;
            h_rdata[d] = 32'd0;
        end
        #1;
        chk(d, "post_strobe", {30'd0, p_re[d], p_we[d]}, 32'd0);
        if (exp_n[d] == 0) begin
            @(negedge clk);
            #1;
            chk(d, "quiet_strobe", {30'd0, p_re[d], p_we[d]}, 32'd0);
            chk(d, "quiet_err", {30'd0, ca_err[d], cb_err[d]}, 32'd0);
        end
    endtask

    // op: 0 none, 1 read, 2 write. Called at a negedge with both instances idle.
    task automatic round(input int a_op, input int b_op,
                         input logic [31:0] a_addr, input logic [31:0] b_addr,
                         input logic [31:0] a_wd, input logic [31:0] b_wd,
                         input logic [3:0] a_ben, input logic [3:0] b_ben,
                         input int lat0, input int lat1, input int resp0, input int resp1,
                         input logic [31:0] rd0, input logic [31:0] rd1);
        bit need_a, need_b;
        t_a_op = a_op; t_b_op = b_op;
        t_a_addr = a_addr; t_b_addr = b_addr;
        t_a_wd = a_wd; t_b_wd = b_wd;
        t_a_ben = a_ben; t_b_ben = b_ben;
        t_lat[0] = lat0; t_lat[1] = lat1;
        t_resp[0] = resp0; t_resp[1] = resp1;
        t_rd[0] = rd0; t_rd[1] = rd1;
        need_a = (a_op != 0);
        need_b = (b_op == 1);
        for (int d = 0; d < 2; d++) begin
            exp_n[d] = 0;
            if (need_a && need_b) begin
                if (d == 1 && !last_b[d]) begin
                    exp_ord[d][0] = 1; exp_ord[d][1] = 0;
                end else begin
                    exp_ord[d][0] = 0; exp_ord[d][1] = 1;
                end
                exp_n[d] = 2;
            end else if (need_a) begin
                exp_ord[d][0] = 0; exp_n[d] = 1;
            end else if (need_b) begin
                exp_ord[d][0] = 1; exp_n[d] = 1;
            end
            if (exp_n[d] > 0) last_b[d] = (exp_ord[d][exp_n[d]-1] == 1);
        end
        ca_addr = a_addr; ca_wdata = a_wd; ca_ben = a_ben;
        cb_addr = b_addr; cb_wdata = b_wd; cb_ben = b_ben;
        ca_re = (a_op == 1); ca_we = (a_op == 2);
        cb_re = (b_op == 1); cb_we = (b_op == 2);
        @(negedge clk);
        ca_re = 1'b0; ca_we = 1'b0; cb_re = 1'b0; cb_we = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, "ro_err_b", 32'(cb_err[d]), 32'(b_op == 2));
            chk(d, "ro_err_a", 32'(ca_err[d]), 32'd0);
        end
        fork
            host(0);
            host(1);
        join
    endtask

    initial begin
        int ao, bo;
        rstn = 1'b0;
        ca_addr = '0; ca_wdata = '0; ca_ben = '0; ca_re = 1'b0; ca_we = 1'b0;
        cb_addr = '0; cb_wdata = '0; cb_ben = '0; cb_re = 1'b0; cb_we = 1'b0;
        for (int d = 0; d < 2; d++) begin
            h_ack[d] = 1'b0; h_err[d] = 1'b0; h_rdata[d] = '0; last_b[d] = 1'b1;
        end
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);

        // A read, host acks 3 cycles after the strobe
        round(1, 0, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0,
              3, 1, 0, 0, 32'hDEAD_BEEF, 32'h0);
        // A write and B read together; RR instance last served A so B goes first there
        round(2, 1, 32'h0000_2000, 32'h0000_0400, 32'h1234_5678, 32'h0, 4'hF, 4'hF,
              2, 2, 0, 0, 32'h0BAD_F00D, 32'hCAFE_0001);
        // Write on read-only port B
        round(0, 2, 32'h0, 32'h0000_0800, 32'h0, 32'h5555_AAAA, 4'h0, 4'hF,
              1, 1, 0, 0, 32'h0, 32'h0);
        // Host error on an A read
        round(1, 0, 32'h0000_3000, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0,
              2, 1, 1, 0, 32'h7777_0000, 32'h0);

        // Reset while B is being served
        ca_addr = '0; ca_wdata = '0; ca_ben = '0;
        cb_addr = 32'h0000_0C00; cb_ben = 4'hF; cb_re = 1'b1;
        @(negedge clk);
        cb_re = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        last_b[0] = 1'b1; last_b[1] = 1'b1;
        round(1, 0, 32'h0000_1004, 32'h0000_0C00, 32'h0, 32'h0, 4'hF, 4'hF,
              1, 1, 0, 0, 32'h1357_9BDF, 32'h0);

        for (int r = 0; r < 40; r++) begin
            ao = int'($urandom_range(0, 2));
            bo = int'($urandom_range(0, 2));
            round(ao, bo, $urandom, $urandom, $urandom, $urandom,
                  4'($urandom), 4'($urandom),
                  int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                  pick_resp(), pick_resp(), $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
